data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
- Data-side memory controller directly downstream of the pipelined processor's Memory stage.
- Consumes the processor data port (DataAddr, DataOut, ReadData, WriteData) and returns DataIn and DataWaitreq.
- Fronts an on-chip word-addressed RAM with a fixed, parameterised access latency.
- Drives DataWaitreq so the processor stalls its Memory stage and all earlier stages.

Parameters:
- WORD_SIZE, 16, data and address width in bits.
- DEPTH, 256, number of RAM words; valid addresses are 0..DEPTH-1.
- LATENCY, 2, wait cycles per access (0..15). 0 means single-cycle, and DataWaitreq is never asserted.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- DataAddr  in  WORD_SIZE  word address of the request.
- DataOut  in  WORD_SIZE  write data from the processor.
- ReadData  in  1  read request.
- WriteData  in  1  write request.
- DataIn  out  WORD_SIZE  read data to the processor; valid only in the completion cycle.
- DataWaitreq  out  1  combinational. 1 means the request is not complete and the processor must hold it.
- AccessError  out  1  sticky error flag.
- ClearError  in  1  clears AccessError on the next edge.

Behaviour:
Request and completion:
- A request is "active" when ReadData or WriteData is 1.
- Commands and address are held stable while DataWaitreq is 1.
- The completion cycle is the cycle in which the request is active and DataWaitreq is 0.
- Write: RAM is written on the rising edge that ends the completion cycle.
- Read: DataIn = RAM[DataAddr], combinational, in the completion cycle. DataIn = 0 in all other cycles.

State machine, states IDLE and WAIT:
- Registers: 4-bit down-counter cnt, latched addr, latched cmd.
- IDLE, no request: DataWaitreq = 0, stay in IDLE.
- IDLE, request, LATENCY = 0: complete in the same cycle, stay in IDLE.
- IDLE, request, LATENCY > 0: DataWaitreq = 1, cnt <= LATENCY-1, latch addr and cmd, go to WAIT.
- WAIT, cnt = 0: DataWaitreq = 0, complete, go to IDLE.
- WAIT, cnt > 0: DataWaitreq = 1, cnt <= cnt-1.

Latency and throughput:
- A request first seen in cycle t completes in cycle t+LATENCY.
- Back-to-back requests: the next request is first seen in the cycle after completion, giving one access per LATENCY+1 cycles.

Boundary conditions:
- Request dropped in WAIT (both commands 0): abort, go to IDLE, no write, DataWaitreq = 0.
- Address or cmd changes in WAIT: restart as a new request. cnt <= LATENCY-1, re-latch addr and cmd, stay in WAIT, DataWaitreq = 1.
- ReadData and WriteData both 1: treated as a write. DataIn = 0 at completion; AccessError <= 1 on the completion edge.
- DataAddr >= DEPTH:
  - Normal latency still applies.
  - Read returns 0; write is discarded.
  - AccessError <= 1 on the completion edge.
- ClearError and a new error on the same edge: the set wins.
- Reset = 1, including mid-WAIT:
  - In that cycle: DataWaitreq = 0, DataIn = 0, no RAM write.
  - On the next edge: state = IDLE, cnt = 0, latched addr and cmd = 0, AccessError = 0.
  - RAM contents are not cleared.

Reset values of outputs:
- DataIn = 0, DataWaitreq = 0, AccessError = 0.

Decomposition:
- Shared package holds:
  - WORD_SIZE.
  - mem_state_t enum {IDLE, WAIT}.
  - mem_cmd_t enum {CMD_NONE, CMD_READ, CMD_WRITE, CMD_BOTH}, encoded from {WriteData, ReadData}.
- One sub-module, data_mem_array:
  - DEPTH x WORD_SIZE storage.
  - Asynchronous read, synchronous write-enable port, no reset.
- data_mem_ctrl contains the FSM, counter, range and error logic, and output muxing.

Test Plan:
- LATENCY=2. Write 0xBEEF to addr 5, then read addr 5 → DataWaitreq 1,1,0 for each access; read completion cycle shows DataIn = 0xBEEF; DataIn = 0 in the wait cycles.
- LATENCY=0. Read addr 3 after writing 0x1234 → DataWaitreq never 1; DataIn = 0x1234 in the same cycle; a write followed by a read in consecutive cycles returns the new value.
- LATENCY=2, DEPTH=256. Read addr 0x0100 → completes after 2 wait cycles with DataIn = 0; AccessError = 1 the next cycle and stays 1 until ClearError is pulsed.
- LATENCY=3. Read addr 7 for 1 cycle, then switch to addr 8 → counter restarts; DataWaitreq stays 1 for 3 further cycles; completion returns RAM[8].
- LATENCY=3. Write addr 9 = 0x00FF, assert Reset in the 2nd wait cycle → next cycle state is IDLE, DataWaitreq = 0; a subsequent read of addr 9 returns its old value (write not committed).
- LATENCY=1. ReadData = WriteData = 1, addr 2, data 0x0A0A → RAM[2] = 0x0A0A; DataIn = 0 at completion; AccessError = 1.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared definitions for the data-side memory controller.
//   WORD_SIZE   : default data/address width
//   mem_state_t : controller FSM states
//   mem_cmd_t   : request command, encoded as {WriteData, ReadData}
package data_mem_pkg;

    localparam int WORD_SIZE = 16;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'b00,
        CMD_READ  = 2'b01,
        CMD_WRITE = 2'b10,
        CMD_BOTH  = 2'b11
    } mem_cmd_t;

    function automatic mem_cmd_t encode_cmd(input logic write, input logic read);
        return mem_cmd_t'({write, read});
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word-addressed RAM behind the data controller.
// Asynchronous read, synchronous write, no reset (contents survive reset).
//   clk   : clock
//   we    : write enable, commits wdata to mem[addr] on the rising edge
//   addr  : word address (shared by read and write)
//   wdata : write data
//   rdata : mem[addr], combinational
module data_mem_array #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-side memory controller sitting after the processor Memory stage.
// Adds a fixed LATENCY of wait cycles to every access and stalls the
// processor through DataWaitreq while the access is in flight.
//
// Handshake: a request is active while ReadData or WriteData is 1. The
// processor holds command, address and write data stable while DataWaitreq
// is 1. The cycle where the request is active and DataWaitreq is 0 is the
// completion cycle: DataIn carries read data only then, and a write commits
// on the edge that ends it.
//
// Ports:
//   Clock, Reset  : clock, synchronous active-high reset
//   DataAddr      : word address of the request
//   DataOut       : write data from the processor
//   ReadData      : read request
//   WriteData     : write request (wins when both are set)
//   DataIn        : read data, zero outside a read completion cycle
//   DataWaitreq   : combinational stall request
//   AccessError   : sticky flag for out-of-range or read+write requests
//   ClearError    : clears AccessError on the next edge (a new error wins)
module data_mem_ctrl #(
    parameter int WORD_SIZE = data_mem_pkg::WORD_SIZE,
    parameter int DEPTH     = 256,
    parameter int LATENCY   = 2
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [WORD_SIZE-1:0] DataAddr,
    input  logic [WORD_SIZE-1:0] DataOut,
    input  logic                 ReadData,
    input  logic                 WriteData,
    output logic [WORD_SIZE-1:0] DataIn,
    output logic                 DataWaitreq,
    output logic                 AccessError,
    input  logic                 ClearError
);

    import data_mem_pkg::*;

    localparam int                 AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WORD_SIZE:0] DEPTH_W  = (WORD_SIZE + 1)'(DEPTH);
    localparam logic [3:0]         CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    mem_state_t           state, state_n;
    logic [3:0]           cnt, cnt_n;
    logic [WORD_SIZE-1:0] addr_q, addr_n;
    mem_cmd_t             cmd_q, cmd_n;

    mem_cmd_t             cmd_now;
    logic                 active;
    logic                 in_range;
    logic                 complete;
    logic                 wait_req;
    logic                 mem_we;
    logic                 err_set;
    logic [WORD_SIZE-1:0] rdata;

    assign cmd_now  = encode_cmd(WriteData, ReadData);
    assign active   = (cmd_now != CMD_NONE);
    assign in_range = ({1'b0, DataAddr} < DEPTH_W);

    // Next state and handshake outputs. Reset forces the outputs quiet in the
    // same cycle, even mid-WAIT, so nothing completes or commits.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        addr_n   = addr_q;
        cmd_n    = cmd_q;
        wait_req = 1'b0;
        complete = 1'b0;
        if (!Reset) begin
            case (state)
                IDLE: begin
                    if (active) begin
                        if (LATENCY == 0) begin
                            complete = 1'b1;
                        end else begin
                            wait_req = 1'b1;
                            cnt_n    = CNT_INIT;
                            addr_n   = DataAddr;
                            cmd_n    = cmd_now;
                            state_n  = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!active) begin
                        // Processor withdrew the request: abort without writing.
                        state_n = IDLE;
                    end else if ((DataAddr != addr_q) || (cmd_now != cmd_q)) begin
                        // A different request replaced the held one: start over.
                        wait_req = 1'b1;
                        cnt_n    = CNT_INIT;
                        addr_n   = DataAddr;
                        cmd_n    = cmd_now;
                    end else if (cnt == 4'd0) begin
                        complete = 1'b1;
                        state_n  = IDLE;
                    end else begin
                        wait_req = 1'b1;
                        cnt_n    = cnt - 4'd1;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            addr_q <= '0;
            cmd_q  <= CMD_NONE;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            addr_q <= addr_n;
            cmd_q  <= cmd_n;
        end
    end

    // Read+write is treated as a write, so WriteData alone selects the write.
    assign mem_we  = complete && WriteData && in_range;
    assign err_set = complete && ((cmd_now == CMD_BOTH) || !in_range);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            AccessError <= 1'b0;
        end else if (err_set) begin
            AccessError <= 1'b1;
        end else if (ClearError) begin
            AccessError <= 1'b0;
        end
    end

    data_mem_array #(
        .WIDTH (WORD_SIZE),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (Clock),
        .we    (mem_we),
        .addr  (DataAddr[AW-1:0]),
        .wdata (DataOut),
        .rdata (rdata)
    );

    assign DataWaitreq = wait_req;
    assign DataIn      = (complete && (cmd_now == CMD_READ) && in_range) ? rdata : '0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: four instances with LATENCY 0..3 share one clock.
// A driver issues requests, pushes the expected read data into exp_q and
// tracks the expected RAM contents and error flag in a plain array model; a
// monitor pops exp_q at every completion cycle it observes.
module tb_data_mem_ctrl;

    localparam int N = 4;

    logic        Clock;
    logic [15:0] addr [N];
    logic [15:0] dout [N];
    logic [15:0] din  [N];
    logic        rd   [N];
    logic        wr   [N];
    logic        rst  [N];
    logic        clr  [N];
    logic        waitreq [N];
    logic        err  [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        data_mem_ctrl #(
            .WORD_SIZE (16),
            .DEPTH     (256),
            .LATENCY   (g)
        ) u_dut (
            .Clock       (Clock),
            .Reset       (rst[g]),
            .DataAddr    (addr[g]),
            .DataOut     (dout[g]),
            .ReadData    (rd[g]),
            .WriteData   (wr[g]),
            .DataIn      (din[g]),
            .DataWaitreq (waitreq[g]),
            .AccessError (err[g]),
            .ClearError  (clr[g])
        );
    end

    // clock
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // reference model and scoreboard
    logic [15:0] ref_mem [N][256];
    logic        ref_err [N];
    logic [17:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d actual=%h expected=%h t=%0t", name, inst, act, exp, $time);
        end
    endtask

    // monitor: completion cycles pop the queue, every other cycle DataIn must be 0
    logic [17:0] mon_e;
    always @(negedge Clock) begin
        for (int i = 0; i < N; i++) begin
            if (!rst[i] && (rd[i] || wr[i]) && !waitreq[i]) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_completion", i, 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("completion_inst", i, i, 32'(mon_e[17:16]));
                    chk("read_data", i, 32'(din[i]), 32'(mon_e[15:0]));
                end
            end else begin
                chk("data_in_idle_zero", i, 32'(din[i]), 32'd0);
            end
        end
    end

    // driver tasks: all start and end 1 time unit after a rising edge
    task automatic do_req(input int i, input bit r, input bit w, input logic [15:0] a,
                          input logic [15:0] d, input bit c);
        logic [15:0] e;
        int          waits;
        bit          bad;
        rd[i]   = r;
        wr[i]   = w;
        addr[i] = a;
        dout[i] = d;
        clr[i]  = 1'b0;
        bad = (r && w) || (a >= 16'd256);
        e   = (r && !w && a < 16'd256) ? ref_mem[i][a[7:0]] : 16'h0000;
        exp_q.push_back({i[1:0], e});
        waits = 0;
        forever begin
            @(negedge Clock);
            if (!waitreq[i]) break;
            waits++;
            if (waits > 40) begin
                chk("completion_timeout", i, waits, i);
                break;
            end
        end
        chk("wait_cycles", i, waits, i);
        clr[i] = c;
        @(posedge Clock);
        if (w && a < 16'd256) ref_mem[i][a[7:0]] = d;
        if (bad) ref_err[i] = 1'b1;
        else if (c) ref_err[i] = 1'b0;
        #1;
        clr[i] = 1'b0;
        chk("access_error", i, 32'(err[i]), 32'(ref_err[i]));
    endtask

    task automatic idle(input int i, input int n);
        rd[i] = 1'b0;
        wr[i] = 1'b0;
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
        chk("error_hold", i, 32'(err[i]), 32'(ref_err[i]));
    endtask

    task automatic clear_err(input int i);
        rd[i]  = 1'b0;
        wr[i]  = 1'b0;
        clr[i] = 1'b1;
        @(posedge Clock);
        #1;
        clr[i] = 1'b0;
        ref_err[i] = 1'b0;
        chk("error_cleared", i, 32'(err[i]), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            addr[i] = '0; dout[i] = '0; rd[i] = 1'b0; wr[i] = 1'b0;
            rst[i] = 1'b1; clr[i] = 1'b0; ref_err[i] = 1'b0;
        end
        repeat (2) @(posedge Clock);
        #1;
        for (int i = 0; i < N; i++) begin
            rst[i] = 1'b0;
            chk("reset_waitreq", i, 32'(waitreq[i]), 32'd0);
            chk("reset_error", i, 32'(err[i]), 32'd0);
            chk("reset_data_in", i, 32'(din[i]), 32'd0);
        end

        // preload so every later read in 0..31 has a known value
        for (int i = 0; i < N; i++) begin
            for (int a = 0; a < 32; a++) begin
                do_req(i, 1'b0, 1'b1, 16'(a), 16'($urandom_range(0, 65535)), 1'b0);
            end
            idle(i, 1);
        end

        // LATENCY=2: write 0xBEEF to 5, read it back
        do_req(2, 1'b0, 1'b1, 16'd5, 16'hBEEF, 1'b0);
        do_req(2, 1'b1, 1'b0, 16'd5, 16'h0000, 1'b0);
        idle(2, 1);

        // LATENCY=0: write then read in consecutive cycles
        do_req(0, 1'b0, 1'b1, 16'd3, 16'h1234, 1'b0);
        do_req(0, 1'b1, 1'b0, 16'd3, 16'h0000, 1'b0);
        idle(0, 1);

        // LATENCY=2: out-of-range read, sticky error, then clear
        do_req(2, 1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0);
        idle(2, 3);
        clear_err(2);
        // out-of-range write discarded; clear on the same edge loses
        do_req(2, 1'b0, 1'b1, 16'h0105, 16'h5555, 1'b1);
        clear_err(2);

        // LATENCY=2: dropped write leaves RAM untouched
        do_req(2, 1'b0, 1'b1, 16'd4, 16'h4444, 1'b0);
        wr[2] = 1'b1; addr[2] = 16'd4; dout[2] = 16'hDEAD;
        @(negedge Clock);
        chk("abort_wait_first", 2, 32'(waitreq[2]), 32'd1);
        @(posedge Clock);
        #1;
        wr[2] = 1'b0;
        @(negedge Clock);
        chk("abort_wait_drop", 2, 32'(waitreq[2]), 32'd0);
        @(posedge Clock);
        #1;
        do_req(2, 1'b1, 1'b0, 16'd4, 16'h0000, 1'b0);
        idle(2, 1);

        // LATENCY=3: read 7 for one cycle then switch to 8 (restart)
        rd[3] = 1'b1; wr[3] = 1'b0; addr[3] = 16'd7;
        @(negedge Clock);
        chk("restart_first_wait", 3, 32'(waitreq[3]), 32'd1);
        @(posedge Clock);
        #1;
        do_req(3, 1'b1, 1'b0, 16'd8, 16'h0000, 1'b0);
        idle(3, 1);

        // LATENCY=3: reset in the second wait cycle of a write
        do_req(3, 1'b0, 1'b1, 16'd9, 16'h1111, 1'b0);
        do_req(3, 1'b1, 1'b1, 16'd10, 16'h2222, 1'b0);
        wr[3] = 1'b1; rd[3] = 1'b0; addr[3] = 16'd9; dout[3] = 16'h00FF;
        @(negedge Clock);
        chk("reset_pre_wait", 3, 32'(waitreq[3]), 32'd1);
        @(posedge Clock);
        #1;
        rst[3] = 1'b1;
        @(negedge Clock);
        chk("reset_cycle_waitreq", 3, 32'(waitreq[3]), 32'd0);
        @(posedge Clock);
        #1;
        rst[3] = 1'b0;
        wr[3]  = 1'b0;
        ref_err[3] = 1'b0;
        @(negedge Clock);
        chk("post_reset_waitreq", 3, 32'(waitreq[3]), 32'd0);
        chk("post_reset_error", 3, 32'(err[3]), 32'd0);
        @(posedge Clock);
        #1;
        do_req(3, 1'b1, 1'b0, 16'd9, 16'h0000, 1'b0);
        idle(3, 1);

        // LATENCY=1: read and write together behave as a write plus error
        do_req(1, 1'b1, 1'b1, 16'd2, 16'h0A0A, 1'b0);
        do_req(1, 1'b1, 1'b0, 16'd2, 16'h0000, 1'b0);
        clear_err(1);

        // randomized traffic on every latency
        for (int i = 0; i < N; i++) begin
            for (int n = 0; n < 40; n++) begin
                int          k;
                bit          r, w, c;
                logic [15:0] a;
                k = $urandom_range(0, 9);
                r = (k <= 4) || (k >= 8);
                w = (k >= 5) && (k <= 8);
                a = ($urandom_range(0, 7) == 0) ? 16'(256 + $urandom_range(0, 1000))
                                                : 16'($urandom_range(0, 31));
                c = ($urandom_range(0, 5) == 0);
                do_req(i, r, w, a, 16'($urandom_range(0, 65535)), c);
                if ($urandom_range(0, 3) == 0) idle(i, 1);
            end
            idle(i, 1);
        end

        @(posedge Clock);
        #1;
        chk("queue_drained", 0, 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
